cache_mem_arbiter: RTL and testbench

- Shares one cacheline-wide physical memory port between the instruction cache and the data cache of the pipelined core.
- Accepts line read requests from the I-cache and line read/write requests from the D-cache.
- Grants one requester at a time, using round-robin on contention.
- Drives registered memory commands, captures the returned line and returns a one-cycle response to the granted cache.
- Sits between the two cache controllers and the cacheline memory adaptor.

---
 rtl/cache_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one cacheline-wide physical memory port between the I-cache and the
// D-cache. One requester is served at a time; when both ask in the same IDLE
// cycle the one that was not served last wins (round-robin). Memory commands
// are registered, the returned line is captured into the winner's rdata
// register and a one-cycle resp pulse is returned in the following cycle.
//
// Parameters
//   width     cacheline width in bits
//   s_offset  byte-offset bits in a line (forced to zero on pmem_address)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_read, i_address             I-cache line read request (held until i_resp)
//   i_rdata, i_resp               line returned to I-cache, one-cycle pulse
//   d_read, d_write, d_address,   D-cache line read / writeback request
//   d_wdata                         (held until d_resp)
//   d_rdata, d_resp               line returned to D-cache, one-cycle pulse
//   pmem_read, pmem_write,        registered memory command, held until
//   pmem_address, pmem_wdata        pmem_resp
//   pmem_rdata, pmem_resp         memory read line and one-cycle completion
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int width    = 256,
  parameter int s_offset = 5
) (
  input  logic             clk,
  input  logic             rst,
  // I-cache side
  input  logic             i_read,
  input  logic [31:0]      i_address,
  output logic [width-1:0] i_rdata,
  output logic             i_resp,
  // D-cache side
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_address,
  input  logic [width-1:0] d_wdata,
  output logic [width-1:0] d_rdata,
  output logic             d_resp,
  // Physical memory side
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [31:0]      pmem_address,
  output logic [width-1:0] pmem_wdata,
  input  logic [width-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_BUSY = 3'd1,
    S_D_BUSY = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  state_t             r_state;
  // 1 when the D-cache was the last requester granted, 0 for the I-cache.
  logic               r_last_d;

  logic               r_pmem_read;
  logic               r_pmem_write;
  logic [31:0]        r_pmem_address;
  logic [width-1:0]   r_pmem_wdata;
  logic [width-1:0]   r_i_rdata;
  logic [width-1:0]   r_d_rdata;
  logic               r_i_resp;
  logic               r_d_resp;

  logic               w_i_req;
  logic               w_d_req;
  logic               w_grant_i;
  logic               w_grant_d;

  // Clear the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [31:0] f_line_addr(input logic [31:0] a);
    f_line_addr = {a[31:s_offset], {s_offset{1'b0}}};
  endfunction

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // On a tie the requester that did not win last time is favoured, so each
  // side waits behind at most one service of the other.
  assign w_grant_i = w_i_req & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_d       <= 1'b1;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_i_resp       <= 1'b0;
      r_d_resp       <= 1'b0;
    end else begin
      // resp pulses last a single cycle unless re-armed below.
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            r_pmem_address <= f_line_addr(i_address);
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
            r_last_d       <= 1'b0;
            r_state        <= S_I_BUSY;
          end else if (w_grant_d) begin
            r_pmem_address <= f_line_addr(d_address);
            r_pmem_wdata   <= d_wdata;
            // A write takes priority if the D-cache illegally raises both.
            r_pmem_write   <= d_write;
            r_pmem_read    <= ~d_write;
            r_last_d       <= 1'b1;
            r_state        <= S_D_BUSY;
          end
        end

        S_I_BUSY: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_rdata    <= pmem_rdata;
            r_i_resp     <= 1'b1;
            r_state      <= S_RESP_I;
          end
        end

        S_D_BUSY: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            // Captured on writes too; the D-cache ignores it in that case.
            r_d_rdata    <= pmem_rdata;
            r_d_resp     <= 1'b1;
            r_state      <= S_RESP_D;
          end
        end

        // The response cycle gives the requester one edge to drop or replace
        // its request before the next arbitration, so a satisfied request is
        // never granted a second time.
        S_RESP_I: r_state <= S_IDLE;
        S_RESP_D: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  assign i_resp       = r_i_resp;
  assign d_resp       = r_d_resp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. A transaction-level reference
// model (one in-flight transaction, a one-cycle turnaround after each response,
// and a "who was served last" marker) predicts every output each cycle.
// Directed scenarios are followed by a long randomized phase.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int W  = 256;
  localparam int SO = 5;
  localparam logic [31:0] LINE_B = 32'd1 << SO;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [W-1:0]  i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [W-1:0]  d_wdata;
  logic [W-1:0]  d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [W-1:0]  pmem_wdata;
  logic [W-1:0]  pmem_rdata;
  logic          pmem_resp;

  cache_mem_arbiter #(.width(W), .s_offset(SO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_inflight: a memory transaction is outstanding for m_owner (1=I, 2=D)
  // m_turn    : the cycle after a response, during which requests are ignored
  // m_last    : requester most recently granted (1=I, 2=D)
  bit           m_inflight;
  bit           m_turn;
  int           m_owner;
  int           m_last;
  logic         e_pread, e_pwrite, e_iresp, e_dresp;
  logic [31:0]  e_addr;
  logic [W-1:0] e_wdata, e_irdata, e_drdata;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a - (a % LINE_B);
  endfunction

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_turn = 0; m_owner = 0; m_last = 2;
    e_pread = 0; e_pwrite = 0; e_iresp = 0; e_dresp = 0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit want_i, want_d, pick_i;
    e_iresp = 0;
    e_dresp = 0;
    if (m_turn) begin
      m_turn = 0;
    end else if (!m_inflight) begin
      want_i = i_read;
      want_d = d_read || d_write;
      pick_i = (want_i && want_d) ? (m_last == 2) : want_i;
      if (want_i || want_d) begin
        m_inflight = 1;
        m_owner    = pick_i ? 1 : 2;
        m_last     = m_owner;
        if (pick_i) begin
          e_addr   = align(i_address);
          e_pread  = 1;
          e_pwrite = 0;
        end else begin
          e_addr   = align(d_address);
          e_wdata  = d_wdata;
          e_pwrite = d_write;
          e_pread  = !d_write;
        end
      end
    end else if (pmem_resp) begin
      e_pread  = 0;
      e_pwrite = 0;
      if (m_owner == 1) begin
        e_irdata = pmem_rdata;
        e_iresp  = 1;
      end else begin
        e_drdata = pmem_rdata;
        e_dresp  = 1;
      end
      m_inflight = 0;
      m_turn     = 1;
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".pmem_read"},    W'(pmem_read),    W'(e_pread));
    chk({ph, ".pmem_write"},   W'(pmem_write),   W'(e_pwrite));
    chk({ph, ".pmem_address"}, W'(pmem_address), W'(e_addr));
    chk({ph, ".pmem_wdata"},   pmem_wdata,       e_wdata);
    chk({ph, ".i_resp"},       W'(i_resp),       W'(e_iresp));
    chk({ph, ".d_resp"},       W'(d_resp),       W'(e_dresp));
    chk({ph, ".i_rdata"},      i_rdata,          e_irdata);
    chk({ph, ".d_rdata"},      d_rdata,          e_drdata);
  endtask

  // One clock: predict, clock, sample 1 time unit after the edge, compare.
  task automatic cycle(input string ph);
    model_step();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
  endtask

  initial begin
    rst = 1'b1;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    #2;
    chk("async_reset.pmem_read", W'(pmem_read), '0);
    do_reset();

    // ---- I-cache read only ----
    i_read = 1; i_address = 32'h0000_1234;
    cycle("ionly");
    chk("ionly.addr_const", W'(pmem_address), W'(32'h0000_1220));
    chk("ionly.read_const", W'(pmem_read), W'(1'b1));
    for (int k = 0; k < 3; k++) cycle("ionly_wait");
    pmem_resp = 1; pmem_rdata = {32{8'hA5}};
    cycle("ionly_resp");
    chk("ionly.iresp_const", W'(i_resp), W'(1'b1));
    chk("ionly.irdata_const", i_rdata, {32{8'hA5}});
    pmem_resp = 0; i_read = 0;
    cycle("ionly_turn");
    chk("ionly.iresp_drop", W'(i_resp), '0);
    cycle("ionly_idle");

    // ---- D-cache writeback ----
    d_write = 1; d_address = 32'h8000_0040; d_wdata = {8{32'hDEAD_BEEF}};
    cycle("dwr");
    chk("dwr.write_const", W'(pmem_write), W'(1'b1));
    chk("dwr.read_const", W'(pmem_read), '0);
    chk("dwr.wdata_const", pmem_wdata, {8{32'hDEAD_BEEF}});
    d_wdata = rand_line(); d_address = $urandom;
    cycle("dwr_wait");
    pmem_resp = 1; pmem_rdata = rand_line();
    cycle("dwr_resp");
    chk("dwr.dresp_const", W'(d_resp), W'(1'b1));
    pmem_resp = 0; d_write = 0;
    cycle("dwr_turn");
    cycle("dwr_idle");

    // ---- ties after reset and back-to-back contention ----
    do_reset();
    i_read = 1; i_address = 32'h0000_2008;
    d_read = 1; d_address = 32'h0000_4051;
    for (int t = 0; t < 5; t++) begin
      cycle("rr_grant");
      chk("rr.order", W'(pmem_address),
          W'((t % 2 == 0) ? 32'h0000_2000 : 32'h0000_4040));
      for (int k = 0; k < 2; k++) begin
        d_wdata = rand_line();
        cycle("rr_wait");
      end
      pmem_resp = 1; pmem_rdata = rand_line();
      cycle("rr_resp");
      pmem_resp = 0;
      cycle("rr_turn");
    end
    idle_inputs();
    cycle("rr_idle");

    // ---- reset in the middle of a D service ----
    d_write = 1; d_address = 32'h0000_0180; d_wdata = rand_line();
    cycle("rst_grant");
    cycle("rst_busy1");
    cycle("rst_busy2");
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid.write_drop", W'(pmem_write), '0);
    chk("rstmid.read_drop", W'(pmem_read), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all("rstmid_held");
    d_write = 0; pmem_resp = 1; pmem_rdata = rand_line();
    cycle("rstmid_late");
    chk("rstmid.no_dresp", W'(d_resp), '0);
    chk("rstmid.no_iresp", W'(i_resp), '0);

    // ---- spurious pmem_resp in IDLE, then illegal read+write ----
    cycle("spur");
    pmem_resp = 0;
    d_read = 1; d_write = 1; d_address = 32'h0000_0A0F; d_wdata = rand_line();
    cycle("illegal");
    chk("illegal.write_const", W'(pmem_write), W'(1'b1));
    chk("illegal.read_const", W'(pmem_read), '0);
    pmem_resp = 1;
    cycle("illegal_resp");
    idle_inputs();
    cycle("illegal_turn");

    // ---- randomized phase ----
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3) == 0) begin
        i_read    = ($urandom_range(2) != 0);
        i_address = $urandom;
      end
      if ($urandom_range(3) == 0) begin
        d_read    = ($urandom_range(2) == 0);
        d_write   = ($urandom_range(2) == 0);
        d_address = $urandom;
        d_wdata   = rand_line();
      end
      pmem_resp  = ($urandom_range(3) == 0);
      pmem_rdata = rand_line();
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
